// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
// Holds the IF->ID bus layout, its field offsets and the fetch-side constants.
package if_pkg;

  localparam int unsigned IF_BUS_W     = 65;
  localparam int unsigned BUS_ADEF_BIT = 0;
  localparam int unsigned BUS_PC_LSB   = 1;
  localparam int unsigned BUS_INST_LSB = 33;

  localparam logic [31:0] INST_NOP   = 32'h0340_0000;
  localparam logic [5:0]  ECODE_ADEF = 6'h08;

  // IF->ID payload: inst in [64:33], pc in [32:1], excep_adef in [0]
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        excep_adef;
  } if_bus_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear.
// Ports: clk/resetn; clear_i empties the FIFO (wins over push/pop);
// push_i/wdata_i write; pop_i/rdata_o read the head (first-word fall-through);
// count_o/full_o/empty_o report occupancy. Push on full is accepted only with a pop.
module if_inst_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Wrap explicitly so non-power-of-two depths work
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer/count next state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Pipelined instruction-fetch stage between an inst_sram-like bus and ID.
// Ports: inst_sram_* request/response bus (write side tied off);
// id_allowin / if_to_id_valid / if_to_id_bus handshake toward ID;
// br_taken/br_target and flush/excep_entry redirects (flush wins); br_stall blocks issue.
// Up to MAX_OUTSTANDING requests in flight; returns land in an IBUF_DEPTH FIFO.
// Responses still in flight at a redirect are counted in cancel_q and discarded.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                inst_sram_req,
  output logic                inst_sram_wr,
  output logic [1:0]          inst_sram_size,
  output logic [3:0]          inst_sram_wstrb,
  output logic [31:0]         inst_sram_wdata,
  output logic [31:0]         inst_sram_addr,
  input  logic                inst_sram_addr_ok,
  input  logic                inst_sram_data_ok,
  input  logic [31:0]         inst_sram_rdata,
  input  logic                id_allowin,
  output logic                if_to_id_valid,
  output logic [IF_BUS_W-1:0] if_to_id_bus,
  input  logic                br_taken,
  input  logic [31:0]         br_target,
  input  logic                br_stall,
  input  logic                flush,
  input  logic [31:0]         excep_entry
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + FCNT_W + 1;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  out_q, out_d, cancel_q, cancel_d;
  logic [CNT_W-1:0]  out_dec, cancel_dec;
  logic              halt_q, halt_d;
  logic              boot_q;
  logic              redirect, accept, ret_push, adef_push, id_pop;
  logic              pc_misaligned, ibuf_room, inflight_room;
  logic [31:0]       redirect_pc;
  if_bus_t           push_bus, head_bus;
  logic [FCNT_W-1:0] ibuf_count;
  logic              ibuf_full, ibuf_empty;
  logic [31:0]       pcq_head;
  logic [CNT_W-1:0]  pcq_count;
  logic              pcq_full, pcq_empty;
  logic              unused_pcq;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'h2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc_q;

  assign redirect      = flush | br_taken;
  assign redirect_pc   = flush ? excep_entry : br_target;
  assign pc_misaligned = |fetch_pc_q[1:0];
  assign ibuf_room     = (SUM_W'(out_q) + SUM_W'(ibuf_count) + SUM_W'(cancel_q)) < SUM_W'(IBUF_DEPTH);
  assign inflight_room = (SUM_W'(out_q) + SUM_W'(cancel_q)) < SUM_W'(MAX_OUTSTANDING);

  // Issue depends only on registered state plus br_stall; data_ok never reaches req
  assign inst_sram_req = boot_q & ~br_stall & ~pc_misaligned & ibuf_room & inflight_room;
  assign accept        = inst_sram_req & inst_sram_addr_ok;

  assign if_to_id_valid = ~ibuf_empty & ~flush;
  assign id_pop         = if_to_id_valid & id_allowin;
  assign if_to_id_bus   = head_bus;

  // Live return: nothing left to cancel and no redirect this cycle
  assign ret_push  = inst_sram_data_ok & (cancel_q == '0) & ~redirect & ~pcq_empty;
  // ADEF entry waits for older live returns so program order is kept
  assign adef_push = pc_misaligned & ~halt_q & ~redirect & (out_q == '0) & (~ibuf_full | id_pop);

  // The PC queue occupancy always equals out_q + cancel_q; only head/empty are needed
  assign unused_pcq = ^{pcq_count, pcq_full};

  always_comb begin
    push_bus.inst       = inst_sram_rdata;
    push_bus.pc         = pcq_head;
    push_bus.excep_adef = 1'b0;
    if (adef_push) begin
      push_bus.inst       = 32'h0;
      push_bus.pc         = fetch_pc_q;
      push_bus.excep_adef = 1'b1;
    end
  end

  // Counter and PC update; a redirect moves every live request into cancel_q
  always_comb begin
    cancel_dec = cancel_q - CNT_W'(inst_sram_data_ok && (cancel_q != '0));
    out_dec    = out_q - CNT_W'(inst_sram_data_ok && (cancel_q == '0));
    fetch_pc_d = fetch_pc_q;
    out_d      = out_dec + CNT_W'(accept);
    cancel_d   = cancel_dec;
    halt_d     = halt_q | adef_push;
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      out_d      = '0;
      cancel_d   = cancel_dec + out_dec + CNT_W'(accept);
      halt_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      cancel_q   <= '0;
      halt_q     <= 1'b0;
      boot_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      cancel_q   <= cancel_d;
      halt_q     <= halt_d;
      boot_q     <= 1'b1;
    end
  end

  if_inst_fifo #(
    .WIDTH (IF_BUS_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (redirect),
    .push_i  (ret_push | adef_push),
    .wdata_i (push_bus),
    .pop_i   (id_pop),
    .rdata_o (head_bus),
    .count_o (ibuf_count),
    .full_o  (ibuf_full),
    .empty_o (ibuf_empty)
  );

  // In-flight PC queue: popped on every return, cancelled or not
  if_inst_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (1'b0),
    .push_i  (accept),
    .wdata_i (fetch_pc_q),
    .pop_i   (inst_sram_data_ok),
    .rdata_o (pcq_head),
    .count_o (pcq_count),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: a bus responder with random latency,
// a program-order reference model fed from observed bus accepts and redirects,
// and a monitor that compares every ID delivery against the model.
module tb_if_prefetch_unit;

  localparam int unsigned MAXO     = 2;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk, resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata, inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin, if_to_id_valid;
  logic [64:0] if_to_id_bus;
  logic        br_taken, br_stall, flush;
  logic [31:0] br_target, excep_entry;

  if_prefetch_unit #(
    .MAX_OUTSTANDING (MAXO),
    .IBUF_DEPTH      (DEPTH),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .id_allowin        (id_allowin),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_bus      (if_to_id_bus),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .br_stall          (br_stall),
    .flush             (flush),
    .excep_entry       (excep_entry)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int delivered = 0;
  int accepts  = 0;

  // Memory contents seen by the fetch unit
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bus responder ----------------
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];
  int aok_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  initial begin
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn) rq.delete();
      else begin
        if (inst_sram_data_ok && rq.size() > 0) void'(rq.pop_front());
        if (inst_sram_req && inst_sram_addr_ok)
          rq.push_back('{inst_sram_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      end
      @(posedge clk); #1;
      inst_sram_addr_ok = ($urandom_range(99, 0) < aok_pct);
      if (resetn && rq.size() > 0 && rq[0].due <= cyc) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mem_f(rq[0].addr);
      end else begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [64:0] exp_q[$];
  logic [31:0] exp_pc = RESET_PC;
  bit          halted = 1'b0;

  initial begin
    logic [64:0] e;
    logic [31:0] tgt;
    bit redir;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        exp_pc = RESET_PC;
        halted = 1'b0;
        continue;
      end
      redir = flush | br_taken;
      if (flush) check("valid_during_flush", 96'(if_to_id_valid), 96'(0));
      if (if_to_id_valid && id_allowin) begin
        if (exp_q.size() == 0) check("spurious_valid", 96'(if_to_id_valid), 96'(0));
        else begin
          e = exp_q.pop_front();
          check("id_bus", 96'(if_to_id_bus), 96'(e));
          delivered++;
        end
      end
      if (halted && !redir) check("req_while_halted", 96'(inst_sram_req), 96'(0));
      if (inst_sram_req && inst_sram_addr_ok) begin
        accepts++;
        if (!halted) begin
          check("fetch_addr", 96'(inst_sram_addr), 96'(exp_pc));
          if (!redir) exp_q.push_back({mem_f(exp_pc), exp_pc, 1'b0});
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redir) begin
        tgt = flush ? excep_entry : br_target;
        exp_q.delete();
        exp_pc = tgt;
        halted = 1'b0;
        if (tgt[1:0] != 2'b00) begin
          exp_q.push_back({32'h0, tgt, 1'b1});
          halted = 1'b1;
        end
      end
    end
  end

  // ---------------- sequencer ----------------
  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("reset_req_clear", 96'(inst_sram_req), 96'(0));
    check("reset_valid_clear", 96'(if_to_id_valid), 96'(0));
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic pulse(input bit f, input bit b, input logic [31:0] ft, input logic [31:0] bt);
    flush = f; br_taken = b; excep_entry = ft; br_target = bt;
    @(posedge clk); #1;
    flush = 1'b0; br_taken = 1'b0;
  endtask

  task automatic wait_inflight(input int n);
    for (int i = 0; i < 50; i++) begin
      if (rq.size() == n) break;
      run(1);
    end
    check("reach_outstanding", 96'(rq.size()), 96'(n));
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_to_id_valid) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_accept(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_sram_req && inst_sram_addr_ok) begin found = 1'b1; break; end
    end
  endtask

  initial begin
    int d0, a0, r;
    bit found;
    logic [31:0] tgt;
    resetn = 1'b0; br_taken = 1'b0; flush = 1'b0; br_stall = 1'b0;
    id_allowin = 1'b1; br_target = 32'h0; excep_entry = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("init_req", 96'(inst_sram_req), 96'(0));
    check("init_valid", 96'(if_to_id_valid), 96'(0));
    check("tie_wr", 96'(inst_sram_wr), 96'(0));
    check("tie_size", 96'(inst_sram_size), 96'(2));
    check("tie_wstrb", 96'(inst_sram_wstrb), 96'(0));
    check("tie_wdata", 96'(inst_sram_wdata), 96'(0));
    resetn = 1'b1;

    // Streaming with immediate returns: one delivery per cycle
    d0 = delivered;
    run(40);
    check("stream_rate", 96'(delivered - d0 >= 34), 96'(1));

    // ID blocked: buffer fills to depth, issue stops, then drains in order
    id_allowin = 1'b0;
    do_reset();
    run(10);
    @(negedge clk);
    check("full_req_off", 96'(inst_sram_req), 96'(0));
    check("full_buffered", 96'(exp_q.size()), 96'(DEPTH));
    check("full_valid", 96'(if_to_id_valid), 96'(1));
    @(posedge clk); #1;
    id_allowin = 1'b1;
    d0 = delivered;
    run(8);
    check("drain_count", 96'(delivered - d0 >= 4), 96'(1));

    // Branch with two stale requests in flight
    lat_min = 5; lat_max = 5;
    do_reset();
    wait_inflight(2);
    pulse(1'b0, 1'b1, 32'h0, 32'h1c00_0100);
    wait_valid(found);
    check("first_pc_after_br", 96'(found ? if_to_id_bus[32:1] : 32'hdead_beef), 96'(32'h1c00_0100));
    @(posedge clk); #1;
    run(20);

    // flush beats a same-cycle branch
    lat_min = 1; lat_max = 1;
    pulse(1'b1, 1'b1, 32'h1c00_8000, 32'h1c00_0200);
    wait_accept(found);
    check("flush_priority_addr", 96'(found ? inst_sram_addr : 32'hdead_beef), 96'(32'h1c00_8000));
    @(posedge clk); #1;
    run(10);

    // Misaligned target raises ADEF and halts fetch
    pulse(1'b0, 1'b1, 32'h0, 32'h1c00_0102);
    wait_valid(found);
    check("adef_entry", 96'(found ? if_to_id_bus : 65'h0), 96'({32'h0, 32'h1c00_0102, 1'b1}));
    @(posedge clk); #1;
    a0 = accepts;
    run(20);
    check("no_fetch_after_adef", 96'(accepts - a0), 96'(0));
    pulse(1'b0, 1'b1, 32'h0, 32'h1c00_0300);
    run(10);

    // Random traffic
    aok_pct = 70; lat_min = 1; lat_max = 6;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      id_allowin = ($urandom_range(99, 0) < 70);
      br_stall   = ($urandom_range(99, 0) < 10);
      r = int'($urandom_range(99, 0));
      tgt = 32'h1c00_0000 + {20'h0, 10'($urandom_range(1023, 0)), 2'b00};
      if ($urandom_range(9, 0) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
      flush       = (r < 2);
      br_taken    = (r < 1) || (r >= 2 && r < 6);
      excep_entry = tgt;
      br_target   = tgt ^ 32'h0000_0040;
      run(1);
    end
    flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0; id_allowin = 1'b1;
    check("random_progress", 96'(delivered > d0), 96'(1));

    // Reset with two requests in flight
    aok_pct = 100; lat_min = 5; lat_max = 5;
    pulse(1'b0, 1'b1, 32'h0, 32'h1c00_0400);
    wait_inflight(2);
    lat_min = 1; lat_max = 1;
    do_reset();
    wait_accept(found);
    check("addr_after_reset", 96'(found ? inst_sram_addr : 32'hdead_beef), 96'(RESET_PC));
    @(posedge clk); #1;
    d0 = delivered;
    run(20);
    check("flow_after_reset", 96'(delivered - d0 >= 15), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised successor to the single-entry IF stage.
- Sits between the inst_sram-like bus and the ID stage.
- Keeps up to MAX_OUTSTANDING fetch requests in flight and buffers returned instructions in an IBUF_DEPTH-entry FIFO.
- Handles branch and flush redirects by discarding buffered and in-flight instructions with a cancel counter, and raises ADEF without issuing a bus request.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-not-returned requests (1..4).
- IBUF_DEPTH, 4: instruction FIFO entries; power of two, ≥ MAX_OUTSTANDING.
- RESET_PC, 32'h1c000000: first fetch address after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req  out  1  fetch request
- inst_sram_wr  out  1  tied 0
- inst_sram_size  out  2  tied 2'h2
- inst_sram_wstrb  out  4  tied 0
- inst_sram_wdata  out  32  tied 0
- inst_sram_addr  out  32  fetch PC
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  data returned, in request order
- inst_sram_rdata  in  32  instruction
- id_allowin  in  1  ID can accept
- if_to_id_valid  out  1  head entry valid
- if_to_id_bus  out  65  {inst[31:0], pc[31:0], excep_adef}
- br_taken  in  1  branch redirect pulse
- br_target  in  32  branch target
- br_stall  in  1  branch unresolved; block issue
- flush  in  1  exception/ertn redirect pulse
- excep_entry  in  32  flush target

Behaviour:
- Reset (async, resetn=0):
  - fetch_pc=RESET_PC.
  - outstanding=0, cancel_cnt=0, FIFO empty, pending redirect cleared.
  - inst_sram_req=0, if_to_id_valid=0.
- Issue condition: req = ~br_stall & ~pc_misaligned & (outstanding + fifo_count + cancel_cnt < IBUF_DEPTH) & (outstanding + cancel_cnt < MAX_OUTSTANDING).
  - inst_sram_addr=fetch_pc.
  - On req & addr_ok: fetch_pc += 4 and the PC is pushed to the in-flight PC queue (depth MAX_OUTSTANDING).
- Return path:
  - On data_ok with cancel_cnt>0: decrement cancel_cnt and drop the data.
  - Otherwise: push {rdata, pc from in-flight queue head, 0} into the FIFO.
  - Pop the in-flight queue on every data_ok.
- ADEF: fetch_pc[1:0]≠0 with FIFO space → push {32'h0, fetch_pc, 1}, no bus request. Fetching then halts until the next redirect.
- Redirect:
  - Priority: flush > br_taken. flush overrides a same-cycle br_taken.
  - Next cycle: FIFO cleared; fetch_pc = target.
  - cancel_cnt = cancel_cnt + outstanding + (req & addr_ok in the redirect cycle).
  - A data_ok arriving in the redirect cycle is dropped and is counted before the add.
  - A request pending without addr_ok may change address on the next cycle.
- Output to ID:
  - if_to_id_valid = FIFO non-empty & ~flush.
  - Pop on valid & id_allowin.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Counters:
  - outstanding is incremented on accept and decremented on data_ok; both in one cycle leaves it unchanged.
  - Counter width is $clog2(MAX_OUTSTANDING+1).
  - cancel_cnt never exceeds MAX_OUTSTANDING.
- br_stall does not block returns or pops, only issue.
- Combinational paths:
  - No combinational path from inst_sram_data_ok to inst_sram_req.
  - The allowed path is from addr_ok to next-cycle state only.

Decomposition:
- Shared package if_pkg: IF_BUS_W=65, bus field offsets, INST_NOP constant, ADEF code.
- Sub-module if_inst_fifo: parametrised sync FIFO (width 65, depth IBUF_DEPTH) with count, full, empty and flush-clear. It is reused for the in-flight PC queue at width 32.

Test Plan:
- Reset release, addr_ok and data_ok always 1, id_allowin=1:
  - Addresses 1c000000, 1c000004, 1c000008… issued back-to-back.
  - ID receives the matching PCs in order, one per cycle after the first.
- id_allowin=0 for 10 cycles with immediate returns:
  - Exactly IBUF_DEPTH entries are buffered and req deasserts.
  - On release, 4 entries drain with pcs 1c000000..1c00000c intact.
- Two requests outstanding, data latency 5, br_taken to 1c000100:
  - The two stale returns are dropped (cancel_cnt 2→0).
  - The first instruction delivered to ID has pc 1c000100.
- flush and br_taken in the same cycle (excep_entry 1c008000, br_target 1c000200):
  - The next issued address is 1c008000.
- br_target=1c000102:
  - One entry with excep_adef=1, pc=1c000102, inst=0.
  - No inst_sram_req is issued until the next redirect.
- resetn asserted low with 2 requests outstanding:
  - Outputs clear immediately.
  - After release, the first address is RESET_PC and counters are 0.
